abm_block_reader: RTL and testbench
===================================

Name: abm_block_reader

Overview:
- Consumes the start_read / read_addr command produced by the AXI4-Lite control block.
- Fetches one block of buffer memory over an AXI4 master read interface, as multiple INCR bursts with bounded outstanding reads.
- Streams the returned data out on an AXI4-Stream master, with TLAST on the block's final beat.
- Reports busy, completion and response errors back for status readout.

Parameters:
- DATA_WIDTH, 512, AXI/AXIS data width in bits; power of two, minimum 32.
- ADDR_WIDTH, 64, AXI address width; read_addr is zero-extended to this width.
- BLOCK_BYTES, 4096, bytes fetched per command; multiple of the burst size.
- BURST_BEATS, 16, beats per AXI burst; 1..256.
- MAX_OUTSTANDING, 4, maximum bursts issued on AR but not yet fully returned on R; 1..15.

Ports:
- clk  in  1  clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- start_read  in  1  single-cycle command pulse.
- read_addr  in  32  byte address of the block; sampled when start_read is accepted.
- busy  out  1  high from command acceptance until the final beat is transferred.
- done  out  1  one-cycle pulse on the cycle after the final beat transfers.
- resp_err  out  1  sticky; set on any RRESP!=0 or RLAST mismatch; cleared by the next accepted command.
- cmd_dropped  out  16  count of start_read pulses ignored while busy; saturates at 0xFFFF.
- M_AXI_ARADDR  out  ADDR_WIDTH  burst address.
- M_AXI_ARLEN  out  8  constant BURST_BEATS-1.
- M_AXI_ARSIZE  out  3  constant log2(DATA_WIDTH/8).
- M_AXI_ARBURST  out  2  constant 1 (INCR).
- M_AXI_ARVALID  out  1  address valid.
- M_AXI_ARREADY  in  1  address ready.
- M_AXI_RDATA  in  DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RLAST  in  1  last beat of burst.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.
- AXIS_OUT_TDATA  out  DATA_WIDTH  stream data.
- AXIS_OUT_TLAST  out  1  final beat of block.
- AXIS_OUT_TVALID  out  1  stream valid.
- AXIS_OUT_TREADY  in  1  stream ready.

Behaviour:
- Derived constants:
  - BEAT_BYTES = DATA_WIDTH/8.
  - BURST_BYTES = BURST_BEATS*BEAT_BYTES.
  - NUM_BURSTS = BLOCK_BYTES/BURST_BYTES.
  - TOTAL_BEATS = BLOCK_BYTES/BEAT_BYTES.
- Reset (asynchronous): all state cleared.
  - busy, done, resp_err, ARVALID, RREADY, TVALID, TLAST = 0; cmd_dropped = 0; FSM = IDLE.
  - Reset mid-operation abandons in-flight transactions. The interconnect shares the same reset; no drain is attempted.
- FSM states: IDLE, RUN, DONE.
  - IDLE: when start_read=1, latch base = zero-extended read_addr, clear ar_count, beat_count, outstanding and resp_err, set busy=1, go to RUN.
  - RUN: the AR and R channels operate independently (below). When the final beat transfers, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE. A start_read arriving in DONE is ignored and counted.
- Command handling:
  - start_read while busy, or in DONE, increments cmd_dropped (saturating at 0xFFFF) and does not disturb the current block.
- AR channel:
  - ARVALID=1 while in RUN, ar_count<NUM_BURSTS and outstanding<MAX_OUTSTANDING.
  - ARADDR = base + ar_count*BURST_BYTES, computed at ADDR_WIDTH; address bits above ADDR_WIDTH are discarded.
  - ARADDR is held stable while ARVALID=1 and ARREADY=0.
  - On ARVALID&ARREADY: ar_count++ and outstanding++.
- R-to-stream path, combinational pass-through with no buffering:
  - TDATA = RDATA.
  - TVALID = RVALID & (state==RUN).
  - RREADY = TREADY & (state==RUN).
  - TLAST = beat_count==TOTAL_BEATS-1.
  - A beat transfers on RVALID&RREADY, and beat_count++ on each transfer.
  - A burst completes when the in-burst beat counter reaches BURST_BEATS-1; outstanding-- on that beat.
  - An AR accept and a burst completion in the same cycle leave outstanding unchanged.
- Error detection, all sticky until the next accepted command:
  - RRESP!=0 on any beat sets resp_err.
  - RLAST disagreeing with the in-burst counter (early or missing) sets resp_err.
  - Counting continues from the internal beat counter; errors never stall or truncate the block.
- Latency:
  - ARVALID rises on the cycle after start_read is accepted.
  - done rises on the cycle after the final beat transfers.
- Back-pressure: TREADY=0 holds RREADY=0 indefinitely. No timeout.

Test Plan:
- Basic block: reset, start_read with read_addr=0x0000_2000, ideal memory, TREADY=1 -> 4 ARs at addresses 0x2000/0x2400/0x2800/0x2C00, ARLEN=15, ARSIZE=6, ARBURST=1; 64 beats with TLAST only on beat 63; done pulses once; resp_err=0.
- Outstanding limit: MAX_OUTSTANDING=2, memory delays RVALID by 50 cycles -> ARVALID drops after 2 accepted ARs; the third AR is issued only after burst 0's last beat.
- Back-pressure: TREADY toggles randomly 50% -> stream data matches memory contents in order, no beat lost or duplicated, RREADY==TREADY throughout RUN.
- Errors: RRESP=2 on beat 10, and RLAST asserted early on beat 5 of burst 2 (in separate runs) -> resp_err=1 in each run, still exactly 64 beats and one done; resp_err cleared by the next start_read.
- Dropped commands: 3 start_read pulses while busy, plus 1 in the DONE cycle -> cmd_dropped=4, base address unchanged, a single done.
- Reset mid-operation: assert reset after 20 beats -> all outputs at reset values immediately (asynchronous); a subsequent start_read produces a clean 64-beat block.

Source files
------------

// File: rtl/abm_block_reader_if.sv
// Bus bundle for abm_block_reader: AXI4 read-address / read-data channels toward buffer memory
// plus the AXI4-Stream output that carries the fetched block.
//   master modport : the block reader (drives AR*, RREADY, AXIS_OUT_TDATA/TLAST/TVALID)
//   slave modport  : memory + stream sink (drives ARREADY, R*, AXIS_OUT_TREADY)
interface abm_block_reader_if #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
    logic [7:0]            M_AXI_ARLEN;
    logic [2:0]            M_AXI_ARSIZE;
    logic [1:0]            M_AXI_ARBURST;
    logic                  M_AXI_ARVALID;
    logic                  M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0] M_AXI_RDATA;
    logic [1:0]            M_AXI_RRESP;
    logic                  M_AXI_RLAST;
    logic                  M_AXI_RVALID;
    logic                  M_AXI_RREADY;
    logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA;
    logic                  AXIS_OUT_TLAST;
    logic                  AXIS_OUT_TVALID;
    logic                  AXIS_OUT_TREADY;

    modport master (
        output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        output M_AXI_RREADY,
        output AXIS_OUT_TDATA, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
        input  AXIS_OUT_TREADY
    );

    modport slave (
        input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
        input  M_AXI_RREADY,
        input  AXIS_OUT_TDATA, AXIS_OUT_TLAST, AXIS_OUT_TVALID,
        output AXIS_OUT_TREADY
    );
endinterface

// File: rtl/abm_block_reader.sv
// Block reader: on a start_read command fetches BLOCK_BYTES from read_addr as INCR bursts of
// BURST_BEATS beats (at most MAX_OUTSTANDING bursts in flight) and passes the returned data
// straight through to an AXI4-Stream master, TLAST on the block's final beat.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   start_read    : command pulse; read_addr sampled when accepted (idle only)
//   busy          : command accepted, final beat not yet transferred
//   done          : one-cycle pulse after the final beat
//   resp_err      : sticky RRESP / RLAST error, cleared by the next accepted command
//   cmd_dropped   : saturating count of commands ignored while busy or done
//   bus           : AXI4 read master + AXI4-Stream master (abm_block_reader_if.master)
module abm_block_reader #(
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned BLOCK_BYTES     = 4096,
    parameter int unsigned BURST_BEATS     = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_read,
    input  logic [31:0] read_addr,
    output logic        busy,
    output logic        done,
    output logic        resp_err,
    output logic [15:0] cmd_dropped,
    abm_block_reader_if.master bus
);

    localparam int unsigned BEAT_BYTES  = DATA_WIDTH / 8;
    localparam int unsigned BURST_BYTES = BURST_BEATS * BEAT_BYTES;
    localparam int unsigned NUM_BURSTS  = BLOCK_BYTES / BURST_BYTES;
    localparam int unsigned TOTAL_BEATS = BLOCK_BYTES / BEAT_BYTES;
    localparam int unsigned ARC_W       = $clog2(NUM_BURSTS + 1);
    localparam int unsigned BC_W        = $clog2(TOTAL_BEATS + 1);
    localparam int unsigned IB_W        = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int unsigned OUT_W       = 4;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ARC_W-1:0]      ar_count_q, ar_count_d;
    logic [BC_W-1:0]       beat_count_q, beat_count_d;
    logic [IB_W-1:0]       ib_count_q, ib_count_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  resp_err_q, resp_err_d;
    logic [15:0]           cmd_dropped_q, cmd_dropped_d;

    logic                  run;
    logic                  ar_hs;
    logic                  r_xfer;
    logic                  burst_end;
    logic [ADDR_WIDTH-1:0] ar_offset;

    assign run       = (state_q == StRun);
    assign ar_hs     = bus.M_AXI_ARVALID & bus.M_AXI_ARREADY;
    assign r_xfer    = bus.M_AXI_RVALID & bus.M_AXI_RREADY;
    assign burst_end = (ib_count_q == IB_W'(BURST_BEATS - 1));
    // Address arithmetic is done at full ADDR_WIDTH so carries past bit 31 are kept.
    assign ar_offset = ADDR_WIDTH'(ar_count_q) * ADDR_WIDTH'(BURST_BYTES);

    // AR channel: ar_count only moves on a handshake, so ARADDR is stable while stalled.
    assign bus.M_AXI_ARVALID = run && (ar_count_q < ARC_W'(NUM_BURSTS))
                               && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
    assign bus.M_AXI_ARADDR  = base_q + ar_offset;
    assign bus.M_AXI_ARLEN   = 8'(BURST_BEATS - 1);
    assign bus.M_AXI_ARSIZE  = 3'($clog2(BEAT_BYTES));
    assign bus.M_AXI_ARBURST = 2'b01;

    // R to stream is a wire-through; back-pressure goes straight to RREADY.
    assign bus.AXIS_OUT_TDATA  = bus.M_AXI_RDATA;
    assign bus.AXIS_OUT_TVALID = bus.M_AXI_RVALID & run;
    assign bus.M_AXI_RREADY    = bus.AXIS_OUT_TREADY & run;
    assign bus.AXIS_OUT_TLAST  = run && (beat_count_q == BC_W'(TOTAL_BEATS - 1));

    assign busy        = busy_q;
    assign done        = done_q;
    assign resp_err    = resp_err_q;
    assign cmd_dropped = cmd_dropped_q;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        ar_count_d    = ar_count_q;
        beat_count_d  = beat_count_q;
        ib_count_d    = ib_count_q;
        outstanding_d = outstanding_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        resp_err_d    = resp_err_q;
        cmd_dropped_d = cmd_dropped_q;

        unique case (state_q)
            StIdle: begin
                if (start_read) begin
                    base_d        = ADDR_WIDTH'(read_addr);
                    ar_count_d    = '0;
                    beat_count_d  = '0;
                    ib_count_d    = '0;
                    outstanding_d = '0;
                    resp_err_d    = 1'b0;
                    busy_d        = 1'b1;
                    state_d       = StRun;
                end
            end
            StRun: begin
                if (ar_hs) begin
                    ar_count_d = ar_count_q + 1'b1;
                end
                if (r_xfer) begin
                    beat_count_d = beat_count_q + 1'b1;
                    ib_count_d   = burst_end ? '0 : ib_count_q + 1'b1;
                    // Errors are only flagged; the internal counters keep the block length.
                    if ((bus.M_AXI_RRESP != 2'b00) || (bus.M_AXI_RLAST != burst_end)) begin
                        resp_err_d = 1'b1;
                    end
                    if (beat_count_q == BC_W'(TOTAL_BEATS - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end
                unique case ({ar_hs, r_xfer & burst_end})
                    2'b10:   outstanding_d = outstanding_q + 1'b1;
                    2'b01:   outstanding_d = outstanding_q - 1'b1;
                    default: outstanding_d = outstanding_q;
                endcase
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start_read && (state_q != StIdle) && (cmd_dropped_q != 16'hFFFF)) begin
            cmd_dropped_d = cmd_dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            base_q        <= '0;
            ar_count_q    <= '0;
            beat_count_q  <= '0;
            ib_count_q    <= '0;
            outstanding_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            resp_err_q    <= 1'b0;
            cmd_dropped_q <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            ar_count_q    <= ar_count_d;
            beat_count_q  <= beat_count_d;
            ib_count_q    <= ib_count_d;
            outstanding_q <= outstanding_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            resp_err_q    <= resp_err_d;
            cmd_dropped_q <= cmd_dropped_d;
        end
    end

endmodule

// File: tb/tb_abm_block_reader.sv
// Directed bench for abm_block_reader: in-order AXI memory model with programmable read
// latency, AR/T back-pressure and error injection; stream checked against expected contents.
module tb_abm_block_reader;

    localparam int unsigned DW   = 512;
    localparam int unsigned AW   = 64;
    localparam int unsigned MAXO = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_read = 1'b0;
    logic [31:0] read_addr = '0;
    logic        busy;
    logic        done;
    logic        resp_err;
    logic [15:0] cmd_dropped;

    abm_block_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    abm_block_reader #(
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .BLOCK_BYTES     (4096),
        .BURST_BEATS     (16),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .start_read  (start_read),
        .read_addr   (read_addr),
        .busy        (busy),
        .done        (done),
        .resp_err    (resp_err),
        .cmd_dropped (cmd_dropped),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [63:0] a);
        logic [DW-1:0] d;
        for (int w = 0; w < DW / 32; w++) begin
            d[w*32 +: 32] = a[31:0] ^ (32'(w) << 24);
        end
        return d;
    endfunction

    // Memory model / monitor state
    typedef struct {
        logic [63:0] addr;
        int          t;
    } ar_ent_t;

    ar_ent_t     arq[$];
    logic [63:0] ar_log[$];
    int          cyc = 0;
    int          rb_beat = 0;
    int          r_gidx = 0;
    int          r_burst = 0;
    int          r_delay = 0;
    bit          bp_mode = 1'b0;
    bit          ar_rand = 1'b0;
    int          err_beat = -1;
    int          err_burst = -1;
    int          err_inburst = -1;
    logic [63:0] exp_base = '0;
    int          t_idx = 0;
    int          data_bad = 0;
    int          last_bad = 0;
    int          rr_bad = 0;
    int          field_bad = 0;
    int          hold_bad = 0;
    int          done_cnt = 0;
    int          issued = 0;
    int          completed = 0;
    int          max_out = 0;
    int          third_ar_cyc = -1;
    int          b0_last_cyc = -1;
    logic        prev_arv = 1'b0;
    logic        prev_arr = 1'b0;
    logic [63:0] prev_araddr = '0;

    task automatic new_run(input logic [63:0] base);
        ar_log.delete();
        exp_base     = base;
        t_idx        = 0;
        data_bad     = 0;
        last_bad     = 0;
        rr_bad       = 0;
        field_bad    = 0;
        hold_bad     = 0;
        done_cnt     = 0;
        issued       = 0;
        completed    = 0;
        max_out      = 0;
        third_ar_cyc = -1;
        b0_last_cyc  = -1;
        r_gidx       = 0;
        r_burst      = 0;
    endtask

    initial begin
        logic        ar_hs_n;
        logic        r_hs_n;
        logic        t_hs_n;
        logic [63:0] ar_addr_n;
        bus.M_AXI_ARREADY   = 1'b0;
        bus.M_AXI_RVALID    = 1'b0;
        bus.M_AXI_RDATA     = '0;
        bus.M_AXI_RRESP     = 2'b00;
        bus.M_AXI_RLAST     = 1'b0;
        bus.AXIS_OUT_TREADY = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs_n   = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
            r_hs_n    = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
            t_hs_n    = bus.AXIS_OUT_TVALID && bus.AXIS_OUT_TREADY;
            ar_addr_n = bus.M_AXI_ARADDR;
            if (!rst) begin
                if (done) done_cnt++;
                if (busy) begin
                    if ((bus.M_AXI_RREADY !== bus.AXIS_OUT_TREADY)
                        || (bus.AXIS_OUT_TVALID !== bus.M_AXI_RVALID)) rr_bad++;
                    if (prev_arv && !prev_arr) begin
                        if (!bus.M_AXI_ARVALID || (bus.M_AXI_ARADDR !== prev_araddr)) hold_bad++;
                    end
                end
                if (ar_hs_n) begin
                    ar_log.push_back(ar_addr_n);
                    issued++;
                    if (ar_log.size() == 3) third_ar_cyc = cyc;
                    if ((bus.M_AXI_ARLEN !== 8'd15) || (bus.M_AXI_ARSIZE !== 3'd6)
                        || (bus.M_AXI_ARBURST !== 2'd1)) field_bad++;
                end
                if (r_hs_n && (rb_beat == 15)) begin
                    completed++;
                    if (r_burst == 0) b0_last_cyc = cyc;
                end
                if (issued - completed > max_out) max_out = issued - completed;
                if (t_hs_n) begin
                    if (bus.AXIS_OUT_TDATA !== mk_data(exp_base + 64'(t_idx) * 64)) data_bad++;
                    if (bus.AXIS_OUT_TLAST !== (t_idx == 63)) last_bad++;
                    t_idx++;
                end
                prev_arv    = bus.M_AXI_ARVALID;
                prev_arr    = bus.M_AXI_ARREADY;
                prev_araddr = bus.M_AXI_ARADDR;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                arq.delete();
                rb_beat          = 0;
                prev_arv         = 1'b0;
                bus.M_AXI_RVALID = 1'b0;
                bus.M_AXI_RLAST  = 1'b0;
                bus.M_AXI_RRESP  = 2'b00;
            end else begin
                if (ar_hs_n) arq.push_back('{addr: ar_addr_n, t: cyc});
                if (r_hs_n) begin
                    r_gidx++;
                    if (rb_beat == 15) begin
                        rb_beat = 0;
                        r_burst++;
                        void'(arq.pop_front());
                    end else begin
                        rb_beat++;
                    end
                end
                if ((arq.size() > 0) && (cyc >= arq[0].t + r_delay)) begin
                    bus.M_AXI_RVALID = 1'b1;
                    bus.M_AXI_RDATA  = mk_data(arq[0].addr + 64'(rb_beat) * 64);
                    bus.M_AXI_RRESP  = (r_gidx == err_beat) ? 2'b10 : 2'b00;
                    bus.M_AXI_RLAST  = (rb_beat == 15)
                                       || ((r_burst == err_burst) && (rb_beat == err_inburst));
                end else begin
                    bus.M_AXI_RVALID = 1'b0;
                end
            end
            bus.M_AXI_ARREADY   = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.AXIS_OUT_TREADY = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_start(input logic [31:0] a);
        @(posedge clk);
        #1;
        start_read = 1'b1;
        read_addr  = a;
        @(posedge clk);
        #1;
        start_read = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
    endtask

    task automatic end_checks(input string tag, input logic exp_err);
        repeat (3) @(negedge clk);
        check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check_eq({tag, "_beats"}, 64'(t_idx), 64'd64);
        check_eq({tag, "_data_bad"}, 64'(data_bad), 64'd0);
        check_eq({tag, "_tlast_bad"}, 64'(last_bad), 64'd0);
        check_eq({tag, "_rready_bad"}, 64'(rr_bad), 64'd0);
        check_eq({tag, "_resp_err"}, 64'(resp_err), 64'(exp_err));
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    task automatic ar_checks(input string tag, input logic [63:0] base);
        logic [63:0] got;
        check_eq({tag, "_ar_count"}, 64'(ar_log.size()), 64'd4);
        check_eq({tag, "_ar_fields"}, 64'(field_bad), 64'd0);
        for (int k = 0; k < 4; k++) begin
            got = (k < ar_log.size()) ? ar_log[k] : '1;
            check_eq($sformatf("%s_araddr%0d", tag, k), got, base + 64'(k) * 64'h400);
        end
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_resp_err", 64'(resp_err), 64'd0);
        check_eq("rst_arvalid", 64'(bus.M_AXI_ARVALID), 64'd0);
        check_eq("rst_tvalid", 64'(bus.AXIS_OUT_TVALID), 64'd0);
        check_eq("rst_tlast", 64'(bus.AXIS_OUT_TLAST), 64'd0);
        check_eq("rst_rready", 64'(bus.M_AXI_RREADY), 64'd0);
        check_eq("rst_cmd_dropped", 64'(cmd_dropped), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic block, ideal memory
        new_run(64'h2000);
        do_start(32'h0000_2000);
        @(negedge clk);
        check_eq("basic_arvalid_lat", 64'(bus.M_AXI_ARVALID), 64'd1);
        check_eq("basic_busy", 64'(busy), 64'd1);
        wait_done(3000);
        end_checks("basic", 1'b0);
        ar_checks("basic", 64'h2000);

        // Outstanding limit with slow memory
        r_delay = 50;
        new_run(64'h8000);
        do_start(32'h0000_8000);
        repeat (30) @(negedge clk);
        check_eq("out_arvalid_low", 64'(bus.M_AXI_ARVALID), 64'd0);
        check_eq("out_ar_issued", 64'(ar_log.size()), 64'd2);
        wait_done(3000);
        end_checks("out", 1'b0);
        ar_checks("out", 64'h8000);
        check_eq("out_max", 64'(max_out), 64'(MAXO));
        check_eq("out_ar3_after_b0", 64'(third_ar_cyc > b0_last_cyc), 64'd1);

        // Back-pressure on stream and AR
        r_delay = 3;
        bp_mode = 1'b1;
        ar_rand = 1'b1;
        new_run(64'h0003_0000);
        do_start(32'h0003_0000);
        wait_done(5000);
        end_checks("bp", 1'b0);
        ar_checks("bp", 64'h0003_0000);
        check_eq("bp_araddr_hold", 64'(hold_bad), 64'd0);
        r_delay = 0;
        bp_mode = 1'b0;
        ar_rand = 1'b0;

        // RRESP error on beat 10
        err_beat = 10;
        new_run(64'h1000);
        do_start(32'h0000_1000);
        wait_done(3000);
        end_checks("rresp", 1'b1);
        err_beat = -1;

        // Early RLAST on beat 5 of burst 2; resp_err cleared on accept
        err_burst   = 2;
        err_inburst = 5;
        new_run(64'h6000);
        do_start(32'h0000_6000);
        @(negedge clk);
        check_eq("rlast_err_cleared", 64'(resp_err), 64'd0);
        wait_done(3000);
        end_checks("rlast", 1'b1);
        err_burst   = -1;
        err_inburst = -1;

        // Clean run afterwards clears the sticky error
        new_run(64'h7000);
        do_start(32'h0000_7000);
        @(negedge clk);
        check_eq("clean_err_cleared", 64'(resp_err), 64'd0);
        wait_done(3000);
        end_checks("clean", 1'b0);

        // Dropped commands: 3 while busy, 1 during the done cycle
        new_run(64'hA000);
        do_start(32'h0000_A000);
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(posedge clk);
            do_start(32'h0000_F000);
        end
        wait_done(3000);
        start_read = 1'b1;
        read_addr  = 32'h0000_F000;
        @(posedge clk);
        #1;
        start_read = 1'b0;
        end_checks("drop", 1'b0);
        ar_checks("drop", 64'hA000);
        check_eq("drop_count", 64'(cmd_dropped), 64'd4);

        // Asynchronous reset mid-block
        new_run(64'h4000);
        do_start(32'h0000_4000);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (t_idx >= 20) break;
        end
        check_eq("mid_beats_reached", 64'(t_idx >= 20), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_arvalid", 64'(bus.M_AXI_ARVALID), 64'd0);
        check_eq("mid_rst_rready", 64'(bus.M_AXI_RREADY), 64'd0);
        check_eq("mid_rst_tvalid", 64'(bus.AXIS_OUT_TVALID), 64'd0);
        check_eq("mid_rst_tlast", 64'(bus.AXIS_OUT_TLAST), 64'd0);
        check_eq("mid_rst_cmd_dropped", 64'(cmd_dropped), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        new_run(64'h5000);
        do_start(32'h0000_5000);
        wait_done(3000);
        end_checks("post_rst", 1'b0);
        ar_checks("post_rst", 64'h5000);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
